// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 8-bit CPU: opcodes, instruction field
// positions and the 2-bit immediate sign extension.
package cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 2;
    localparam int RD_MSB = 1;
    localparam int RD_LSB = 0;

    function automatic logic [7:0] sext2(input logic [1:0] v);
        return {{6{v[1]}}, v};
    endfunction

endpackage

// File: rtl/clk_div.sv
// Derives the CPU clock CLK_ from the board clock and flags the board-clock
// edge on which CLK_ falls, which is when architectural state commits.
module clk_div #(
    parameter int DIV_HALF = 1
) (
    input  logic _CLK,
    input  logic RESET,
    output logic CLK_,
    output logic commit_en
);

    localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_HALF - 1);

    logic [CW-1:0] cnt_r;
    logic          clk_r;
    logic          wrap_s;

    assign wrap_s    = (cnt_r == CNT_LAST);
    assign commit_en = wrap_s & clk_r;
    assign CLK_      = clk_r;

    // Half-period counter and CPU clock toggle
    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            cnt_r <= '0;
            clk_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            clk_r <= ~clk_r;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/simple_cpu_datapath.sv
// Single-cycle 8-bit CPU: 4 registers, internal data memory, external
// instruction fetch by PC, last result shown as two display nibbles.
module simple_cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DIV_HALF   = 1,
    parameter int DMEM_DEPTH = 32
) (
    input  logic       _CLK,
    input  logic       RESET,
    input  logic [7:0] instruction,
    output logic [7:0] PC,
    output logic [3:0] m,
    output logic [3:0] l,
    output logic       CLK_
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic          commit_s;
    logic [7:0]    pc_r;
    logic [7:0]    disp_r;
    logic [7:0]    regs_r [4];
    logic [7:0]    dmem_r [DMEM_DEPTH];

    logic [1:0]    op_s, rs_s, rt_s, rd_s;
    logic [7:0]    imm_s, rs_val_s, rt_val_s, sum_s, load_s, pc_inc_s;
    logic [AW-1:0] addr_s;

    logic          reg_we_s, mem_we_s, disp_we_s;
    logic [1:0]    reg_wa_s;
    logic [7:0]    reg_wd_s, mem_wd_s, disp_wd_s, pc_next_s;

    clk_div #(.DIV_HALF(DIV_HALF)) u_clk_div (
        ._CLK      (_CLK),
        .RESET     (RESET),
        .CLK_      (CLK_),
        .commit_en (commit_s)
    );

    assign op_s     = instruction[OP_MSB:OP_LSB];
    assign rs_s     = instruction[RS_MSB:RS_LSB];
    assign rt_s     = instruction[RT_MSB:RT_LSB];
    assign rd_s     = instruction[RD_MSB:RD_LSB];
    assign imm_s    = sext2(rd_s);
    assign rs_val_s = regs_r[rs_s];
    assign rt_val_s = regs_r[rt_s];
    assign sum_s    = rs_val_s + rt_val_s;
    assign addr_s   = AW'(rs_val_s + imm_s);
    assign load_s   = dmem_r[addr_s];
    assign pc_inc_s = pc_r + 8'd1;

    // Decode: every write is gated by the opcode so unused (possibly X) fields cannot leak into state
    always_comb begin
        reg_we_s  = 1'b0;
        reg_wa_s  = 2'b00;
        reg_wd_s  = 8'h00;
        mem_we_s  = 1'b0;
        mem_wd_s  = 8'h00;
        disp_we_s = 1'b0;
        disp_wd_s = 8'h00;
        pc_next_s = pc_inc_s;
        case (op_s)
            OP_ADD: begin
                reg_we_s  = 1'b1;
                reg_wa_s  = rd_s;
                reg_wd_s  = sum_s;
                disp_we_s = 1'b1;
                disp_wd_s = sum_s;
            end
            OP_LW: begin
                reg_we_s  = 1'b1;
                reg_wa_s  = rt_s;
                reg_wd_s  = load_s;
                disp_we_s = 1'b1;
                disp_wd_s = load_s;
            end
            OP_SW: begin
                mem_we_s  = 1'b1;
                mem_wd_s  = rt_val_s;
                disp_we_s = 1'b1;
                disp_wd_s = rt_val_s;
            end
            OP_J: begin
                pc_next_s = pc_inc_s + imm_s;
            end
            default: begin
                pc_next_s = pc_inc_s;
            end
        endcase
    end

    // Architectural state commits on the board edge that drops CLK_
    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            pc_r   <= 8'h00;
            disp_r <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_r[i] <= 8'(i);
            end
        end else if (commit_s) begin
            pc_r <= pc_next_s;
            if (reg_we_s) begin
                regs_r[reg_wa_s] <= reg_wd_s;
            end
            if (mem_we_s) begin
                dmem_r[addr_s] <= mem_wd_s;
            end
            if (disp_we_s) begin
                disp_r <= disp_wd_s;
            end
        end
    end

    assign PC = pc_r;
    assign m  = disp_r[7:4];
    assign l  = disp_r[3:0];

endmodule

// File: tb/tb_simple_cpu_datapath.sv
// Directed program test for simple_cpu_datapath: fetch on rising CLK_,
// check PC and display after each commit, plus reset behaviour.
module tb_simple_cpu_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic [7:0] pc;
    logic [3:0] m;
    logic [3:0] l;
    logic       cpu_clk;

    int checks   = 0;
    int failures = 0;
    int commits  = 0;

    simple_cpu_datapath #(.DIV_HALF(1), .DMEM_DEPTH(32)) dut (
        ._CLK        (clk),
        .RESET       (rst),
        .instruction (instruction),
        .PC          (pc),
        .m           (m),
        .l           (l),
        .CLK_        (cpu_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge cpu_clk) commits = commits + 1;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'd0:    return 8'h71;
            8'd1:    return 8'h4D;
            8'd2:    return 8'h74;
            8'd3:    return 8'hB7;
            8'd4:    return 8'h05;
            8'd5:    return 8'b11xx_xx10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next commit (bounded); returns board edges taken, samples #1 after the edge
    task automatic cpu_step(output int edges);
        int start;
        start = commits;
        edges = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            edges = edges + 1;
            if (commits != start) break;
        end
        if (commits == start) check_eq("commit_timeout", 32'd0, 32'd1);
    endtask

    // External instruction memory fetches on rising CLK_
    initial begin
        instruction = rom(8'd0);
        forever begin
            @(posedge cpu_clk);
            instruction = rom(pc);
        end
    end

    initial begin
        int e;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_pc", {24'd0, pc}, 32'd0);
        check_eq("rst_m", {28'd0, m}, 32'd0);
        check_eq("rst_l", {28'd0, l}, 32'd0);
        check_eq("rst_clk", {31'd0, cpu_clk}, 32'd0);
        rst = 1'b0;

        cpu_step(e);
        check_eq("lw71_edges", e, 32'd2);
        check_eq("lw71_pc", {24'd0, pc}, 32'd1);
        check_eq("lw71_disp", {24'd0, m, l}, 32'h01);
        cpu_step(e);
        check_eq("lw4d_pc", {24'd0, pc}, 32'd2);
        check_eq("lw4d_disp", {24'd0, m, l}, 32'h02);
        cpu_step(e);
        check_eq("lw74_pc", {24'd0, pc}, 32'd3);
        check_eq("lw74_disp", {24'd0, m, l}, 32'h02);
        cpu_step(e);
        check_eq("swb7_pc", {24'd0, pc}, 32'd4);
        check_eq("swb7_disp", {24'd0, m, l}, 32'h02);
        cpu_step(e);
        check_eq("add05_pc", {24'd0, pc}, 32'd5);
        check_eq("add05_disp", {24'd0, m, l}, 32'h03);
        check_eq("cpu_period_edges", e, 32'd2);
        cpu_step(e);
        check_eq("jc2_pc", {24'd0, pc}, 32'd4);
        check_eq("jc2_disp_held", {24'd0, m, l}, 32'h03);

        // r1 climbs by one per loop pass and wraps to 0 on the last pass
        for (int k = 0; k < 253; k++) begin
            cpu_step(e);
            if (k == 0)   check_eq("loop_r1_4", {24'd0, m, l}, 32'h04);
            if (k == 12)  check_eq("loop_r1_16", {24'd0, m, l}, 32'h10);
            if (k == 251) check_eq("loop_r1_255", {24'd0, m, l}, 32'hFF);
            if (k == 252) begin
                check_eq("wrap_disp", {24'd0, m, l}, 32'h00);
                check_eq("wrap_pc", {24'd0, pc}, 32'd5);
            end
            cpu_step(e);
            if (k == 252) check_eq("wrap_jpc", {24'd0, pc}, 32'd4);
        end
        cpu_step(e);
        check_eq("post_wrap_disp", {24'd0, m, l}, 32'h01);

        // Reset mid-run while CLK_ is high
        for (int i = 0; i < 8; i++) begin
            if (cpu_clk === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check_eq("mid_clk_high", {31'd0, cpu_clk}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_pc", {24'd0, pc}, 32'd0);
        check_eq("mid_rst_disp", {24'd0, m, l}, 32'h00);
        check_eq("mid_rst_clk", {31'd0, cpu_clk}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cpu_step(e);
        check_eq("rerun_pc", {24'd0, pc}, 32'd1);
        check_eq("rerun_dmem1", {24'd0, m, l}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
